neo_spike_detector: RTL and testbench

Threshold-and-detect stage directly downstream of the NEO calculator. It makes two passes over the M-entry NEO output memory:
- Pass 1 accumulates the positive NEO energy and derives an adaptive threshold of C times the mean.
- Pass 2 flags every sample that exceeds the threshold, with a refractory hold-off after each detection.

Detections stream out as single-cycle pulses with their address. A running count is kept for the spike-sorting/telemetry logic.

---
 rtl/neo_spike_detector.sv | 134 +++++++++++++
 tb/tb_neo_spike_detector.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_spike_detector.sv
// Two-pass NEO threshold detector: pass 1 sums positive energy to form C x mean,
// pass 2 streams out samples above that threshold with a refractory hold-off.
module neo_spike_detector #(
    parameter int N       = 8,
    parameter int M       = 16,
    parameter int C       = 4,
    parameter int REFRACT = 2,
    localparam int AW     = $clog2(M) + 1,
    localparam int TW     = N + $clog2(C)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic signed [N-1:0] rdata_i,
    output logic [AW-1:0]       raddr_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                spike_o,
    output logic [AW-1:0]       spike_addr_o,
    output logic [AW-1:0]       spike_count_o,
    output logic [TW-1:0]       threshold_o
);

    localparam int IW   = $clog2(M);
    localparam int CW   = $clog2(C);
    localparam int SW   = N + IW;
    localparam int RW   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    typedef enum logic [2:0] {IDLE, ACCUM, CALC, DETECT, DONE} state_e;

    state_e              state_q;
    logic [IW-1:0]       idx_q;
    logic [SW-1:0]       sum_q;
    logic [RW-1:0]       refr_q;
    logic                busy_q;
    logic                done_q;
    logic                spike_q;
    logic [AW-1:0]       spike_addr_q;
    logic [AW-1:0]       spike_count_q;
    logic [TW-1:0]       threshold_q;

    logic [SW-1:0]       sum_d;
    logic [SW+CW-1:0]    scaled_d;
    logic [TW-1:0]       threshold_d;
    logic                above_d;
    logic                lastIdx;

    // Negative energy is clamped to zero; the compare widens both sides by one bit
    // so the unsigned threshold never looks negative.
    always_comb begin
        sum_d       = sum_q + (rdata_i[N-1] ? '0 : {{(SW-N){1'b0}}, rdata_i});
        scaled_d    = (SW+CW)'(sum_q) << CW;
        threshold_d = scaled_d[SW+CW-1:IW];
        above_d     = $signed({{(CW+1){rdata_i[N-1]}}, rdata_i}) > $signed({1'b0, threshold_q});
        lastIdx     = (idx_q == IW'(M - 1));
        raddr_o     = '0;
        if (state_q == ACCUM || state_q == DETECT) begin
            raddr_o = {1'b0, idx_q};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            sum_q         <= '0;
            refr_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            spike_q       <= 1'b0;
            spike_addr_q  <= '0;
            spike_count_q <= '0;
            threshold_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    spike_q <= 1'b0;
                    if (start_i) begin
                        state_q       <= ACCUM;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        idx_q         <= '0;
                        sum_q         <= '0;
                        refr_q        <= '0;
                        spike_addr_q  <= '0;
                        spike_count_q <= '0;
                    end
                end
                ACCUM: begin
                    sum_q <= sum_d;
                    if (lastIdx) begin
                        state_q <= CALC;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                CALC: begin
                    threshold_q <= threshold_d;
                    state_q     <= DETECT;
                end
                DETECT: begin
                    if (refr_q == '0 && above_d) begin
                        spike_q       <= 1'b1;
                        spike_addr_q  <= {1'b0, idx_q};
                        spike_count_q <= spike_count_q + AW'(1);
                        refr_q        <= RW'(REFRACT);
                    end else if (refr_q != '0) begin
                        refr_q  <= refr_q - RW'(1);
                        spike_q <= 1'b0;
                    end else begin
                        spike_q <= 1'b0;
                    end
                    if (lastIdx) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign spike_o       = spike_q;
    assign spike_addr_o  = spike_addr_q;
    assign spike_count_o = spike_count_q;
    assign threshold_o   = threshold_q;

endmodule

// File: tb/tb_neo_spike_detector.sv
// Bench for neo_spike_detector: a run-level reference model predicts every output
// per cycle, and directed runs pin hand-computed thresholds and detections.
module tb_neo_spike_detector;

    localparam int N       = 8;
    localparam int M       = 16;
    localparam int C       = 4;
    localparam int REFRACT = 2;
    localparam int AW      = $clog2(M) + 1;
    localparam int TW      = N + $clog2(C);

    logic                clk = 1'b0;
    logic                rstN;
    logic                start;
    logic signed [N-1:0] rdata;
    logic [AW-1:0]       raddr;
    logic                busy;
    logic                done;
    logic                spike;
    logic [AW-1:0]       spikeAddr;
    logic [AW-1:0]       spikeCount;
    logic [TW-1:0]       threshold;

    logic signed [N-1:0] mem [M];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int modelThr = 0;
    int prevThr = 0;
    bit flag [M];
    bit haveRun = 1'b0;
    bit checkEn = 1'b0;
    int startCyc = 0;
    int busyCnt = 0;
    int spikeCnt = 0;

    neo_spike_detector #(.N(N), .M(M), .C(C), .REFRACT(REFRACT)) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .start_i       (start),
        .rdata_i       (rdata),
        .raddr_o       (raddr),
        .busy_o        (busy),
        .done_o        (done),
        .spike_o       (spike),
        .spike_addr_o  (spikeAddr),
        .spike_count_o (spikeCount),
        .threshold_o   (threshold)
    );

    always #5 clk = ~clk;

    assign rdata = mem[raddr[AW-2:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Whole-run reference: mean-based threshold, then a scan with hold-off.
    task automatic runModel();
        int sum;
        int refr;
        sum = 0;
        for (int i = 0; i < M; i++) if (mem[i] > 0) sum += int'(mem[i]);
        modelThr = sum * C / M;
        refr = 0;
        for (int i = 0; i < M; i++) begin
            flag[i] = 1'b0;
            if (refr == 0 && int'(mem[i]) > modelThr) begin
                flag[i] = 1'b1;
                refr = REFRACT;
            end else if (refr > 0) begin
                refr--;
            end
        end
    endtask

    task automatic recordStart();
        if (!haveRun) prevThr = 0;
        else if (cyc - startCyc >= M + 1) prevThr = modelThr;
        runModel();
        startCyc = cyc;
        haveRun = 1'b1;
        busyCnt = 0;
        spikeCnt = 0;
    endtask

    always @(negedge clk) begin : compare
        int k;
        int eBusy, eDone, eSpike, eCount, eAddr, eThr, eRaddr;
        bit chkRaddr;
        if (checkEn) begin
            eBusy = 0; eDone = 0; eSpike = 0; eCount = 0; eAddr = 0; eThr = 0; eRaddr = 0;
            chkRaddr = 1'b1;
            if (haveRun) begin
                k = cyc - startCyc;
                eBusy = (k <= 2 * M) ? 1 : 0;
                eDone = (k >= 2 * M + 1) ? 1 : 0;
                eThr  = (k >= M + 1) ? modelThr : prevThr;
                for (int i = 0; i < M; i++) begin
                    if (flag[i] && (M + 2 + i) <= k) begin
                        eCount++;
                        eAddr = i;
                        if ((M + 2 + i) == k) eSpike = 1;
                    end
                end
                if (k < M) eRaddr = k;
                else if (k >= M + 1 && k <= 2 * M) eRaddr = k - M - 1;
                else chkRaddr = 1'b0;
                busyCnt += int'(busy);
                spikeCnt += int'(spike);
            end
            checkOutput("busy", 32'(busy), eBusy);
            checkOutput("done", 32'(done), eDone);
            checkOutput("spike", 32'(spike), eSpike);
            checkOutput("spike_count", 32'(spikeCount), eCount);
            checkOutput("spike_addr", 32'(spikeAddr), eAddr);
            checkOutput("threshold", 32'(threshold), eThr);
            if (chkRaddr) checkOutput("raddr", 32'(raddr), eRaddr);
        end
    end

    task automatic applyStimulus(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        recordStart();
        if (!hold) start = 1'b0;
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        checkOutput("done_seen", 32'(seen), 1);
        checkOutput("done_latency", cyc - startCyc, 2 * M + 1);
    endtask

    task automatic finishRun(input int eThr, input int eCnt, input int eAddr, input int ePulses);
        waitDone();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("run_threshold", 32'(threshold), eThr);
        checkOutput("run_count", 32'(spikeCount), eCnt);
        checkOutput("run_addr", 32'(spikeAddr), eAddr);
        checkOutput("run_pulses", spikeCnt, ePulses);
        checkOutput("run_busy_cycles", busyCnt, 2 * M + 1);
        checkOutput("run_done", 32'(done), 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_raddr"}, 32'(raddr), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_spike"}, 32'(spike), 0);
        checkOutput({tag, "_spike_addr"}, 32'(spikeAddr), 0);
        checkOutput({tag, "_spike_count"}, 32'(spikeCount), 0);
        checkOutput({tag, "_threshold"}, 32'(threshold), 0);
    endtask

    task automatic fillMem(input int base);
        for (int i = 0; i < M; i++) mem[i] = N'(base);
    endtask

    initial begin
        rstN = 1'b0;
        start = 1'b0;
        fillMem(0);
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rstN = 1'b1;
        checkEn = 1'b1;
        repeat (3) @(posedge clk);

        // All-zero memory: nothing to detect.
        applyStimulus(1'b0);
        finishRun(0, 0, 0, 0);

        // Flat 2s with one large sample: sum 130, threshold 32.
        fillMem(2);
        mem[5] = 8'sd100;
        applyStimulus(1'b0);
        finishRun(32, 1, 5, 1);

        // Neighbouring peaks: address 4 falls inside the hold-off after 3.
        fillMem(0);
        mem[3] = 8'sd100; mem[4] = 8'sd100; mem[6] = 8'sd100;
        applyStimulus(1'b0);
        finishRun(75, 2, 6, 2);

        // Negative energy is ignored: sum 10, threshold 2.
        fillMem(-50);
        mem[0] = 8'sd10;
        applyStimulus(1'b0);
        finishRun(2, 1, 0, 1);
        mem[0] = 8'sd2;
        applyStimulus(1'b0);
        finishRun(0, 1, 0, 1);

        // Sample equal to threshold (20) is not a spike; start held across DONE.
        fillMem(4);
        mem[0] = 8'sd20;
        applyStimulus(1'b1);
        waitDone();
        checkOutput("eq_threshold", 32'(threshold), 20);
        checkOutput("eq_count", 32'(spikeCount), 0);
        @(posedge clk);
        #1;
        recordStart();
        start = 1'b0;
        checkOutput("restart_done_low", 32'(done), 0);
        checkOutput("restart_busy", 32'(busy), 1);
        finishRun(20, 0, 0, 0);

        // Start pulsed during ACCUM is ignored.
        fillMem(2);
        mem[5] = 8'sd100;
        applyStimulus(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finishRun(32, 1, 5, 1);

        // Start in DONE clears the count and drops done on that edge.
        fillMem(0);
        mem[3] = 8'sd100; mem[4] = 8'sd100; mem[6] = 8'sd100;
        applyStimulus(1'b0);
        checkOutput("done_restart_done", 32'(done), 0);
        checkOutput("done_restart_count", 32'(spikeCount), 0);
        finishRun(75, 2, 6, 2);

        // Reset during DETECT after the spike at address 5, then a clean rerun.
        fillMem(2);
        mem[5] = 8'sd100;
        applyStimulus(1'b0);
        repeat (25) @(posedge clk);
        #3;
        checkOutput("pre_reset_count", 32'(spikeCount), 1);
        checkEn = 1'b0;
        rstN = 1'b0;
        #1;
        checkAllZero("midrun_reset");
        haveRun = 1'b0;
        prevThr = 0;
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        applyStimulus(1'b0);
        finishRun(32, 1, 5, 1);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
